// File: rtl/chip8_mem_writer.sv
// CHIP-8 memory write engine: ROM stream load, FX55 register dump and FX33 BCD store,
// producing one registered byte write per cycle, one job at a time.
module chip8_mem_writer #(
    parameter logic [11:0] LOAD_BASE = 12'h200,
    parameter logic [11:0] MEM_TOP   = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        st_req,
    input  logic        st_mode,
    input  logic [11:0] st_base,
    input  logic [3:0]  st_count,
    input  logic [7:0]  st_value,
    output logic [3:0]  reg_idx,
    input  logic [7:0]  reg_data,
    output logic        mem_we,
    output logic [11:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [2:0] {IDLE, LOAD, DUMP, B0, B1, B2, FIN} state_t;

    state_t      state, state_d;
    logic [11:0] ptr, ptr_d;
    logic [3:0]  cnt, cnt_d, last, last_d;
    logic [7:0]  dig_h, dig_t, dig_o, dig_h_d, dig_t_d, dig_o_d;
    logic        we_d, done_d, ovf_d;
    logic [11:0] waddr_d;
    logic [7:0]  wdata_d;
    logic        hs;

    assign load_ready = (state == LOAD);
    assign busy       = (state != IDLE);
    assign reg_idx    = cnt;
    assign hs         = load_valid & load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            last      <= '0;
            dig_h     <= '0;
            dig_t     <= '0;
            dig_o     <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            last      <= last_d;
            dig_h     <= dig_h_d;
            dig_t     <= dig_t_d;
            dig_o     <= dig_o_d;
            mem_we    <= we_d;
            mem_waddr <= waddr_d;
            mem_wdata <= wdata_d;
            done      <= done_d;
            overflow  <= ovf_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        last_d  = last;
        dig_h_d = dig_h;
        dig_t_d = dig_t;
        dig_o_d = dig_o;
        we_d    = 1'b0;
        waddr_d = mem_waddr;
        wdata_d = mem_wdata;
        done_d  = 1'b0;
        ovf_d   = overflow;
        case (state)
            IDLE: begin
                // load has priority; a simultaneous store request is dropped
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = LOAD_BASE;
                    ovf_d   = 1'b0;
                end else if (st_req) begin
                    ptr_d = st_base;
                    if (!st_mode) begin
                        state_d = DUMP;
                        cnt_d   = '0;
                        last_d  = st_count;
                    end else begin
                        state_d = B0;
                        dig_h_d = st_value / 8'd100;
                        dig_t_d = (st_value / 8'd10) % 8'd10;
                        dig_o_d = st_value % 8'd10;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = ptr;
                    wdata_d = load_data;
                    ptr_d   = ptr + 12'd1;
                    if (load_last) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else if (ptr == MEM_TOP) begin
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            DUMP: begin
                we_d    = 1'b1;
                waddr_d = ptr;
                wdata_d = reg_data;
                ptr_d   = ptr + 12'd1;
                if (cnt == last) begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            B0: begin
                we_d    = 1'b1;
                waddr_d = ptr;
                wdata_d = dig_h;
                ptr_d   = ptr + 12'd1;
                state_d = B1;
            end
            B1: begin
                we_d    = 1'b1;
                waddr_d = ptr;
                wdata_d = dig_t;
                ptr_d   = ptr + 12'd1;
                state_d = B2;
            end
            B2: begin
                we_d    = 1'b1;
                waddr_d = ptr;
                wdata_d = dig_o;
                ptr_d   = ptr + 12'd1;
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip8_mem_writer.sv
// Bench for chip8_mem_writer: scoreboarded write checks, job table plus load/reset/arbitration sequences.
module tb_chip8_mem_writer;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
        logic        dn;
    } wr_t;

    typedef struct {
        logic        mode;
        logic [11:0] base;
        logic [3:0]  cnt;
        logic [7:0]  val;
        logic [7:0]  e0, e1, e2;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [7:0]  load_data = '0;
    logic        st_req = 1'b0, st_mode = 1'b0;
    logic [11:0] st_base = '0;
    logic [3:0]  st_count = '0;
    logic [7:0]  st_value = '0;
    logic [7:0]  reg_data;
    logic [3:0]  reg_idx;
    logic        load_ready, mem_we, busy, done, overflow;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;

    // second instance, based near the top of memory for the overflow case
    logic        load_start_b = 1'b0;
    logic        st_req_b = 1'b0;
    logic [7:0]  reg_data_b = '0;
    logic [3:0]  reg_idx_b;
    logic        load_ready_b, mem_we_b, busy_b, done_b, overflow_b;
    logic [11:0] mem_waddr_b;
    logic [7:0]  mem_wdata_b;

    logic [7:0]  vregs [16];
    wr_t         qa[$], qb[$];
    int          nvec = 0, nerr = 0;
    logic        mon_a = 1'b0, mon_b = 1'b0;

    assign reg_data = vregs[reg_idx];

    always #5 clk = ~clk;

    chip8_mem_writer dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .st_req(st_req), .st_mode(st_mode), .st_base(st_base), .st_count(st_count),
        .st_value(st_value), .reg_idx(reg_idx), .reg_data(reg_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow)
    );

    chip8_mem_writer #(.LOAD_BASE(12'hFFE), .MEM_TOP(12'hFFF)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start_b), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready_b),
        .st_req(st_req_b), .st_mode(st_mode), .st_base(st_base), .st_count(st_count),
        .st_value(st_value), .reg_idx(reg_idx_b), .reg_data(reg_data_b),
        .mem_we(mem_we_b), .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b),
        .busy(busy_b), .done(done_b), .overflow(overflow_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitors: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (mon_a) begin
            if (mem_we) begin
                if (qa.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL a_unexpected_write: got addr %0h data %0h, expected none", mem_waddr, mem_wdata);
                end else begin
                    wr_t e;
                    e = qa.pop_front();
                    chk("a_wr", {mem_waddr, mem_wdata, done}, {e.a, e.d, e.dn});
                end
            end else if (done) begin
                nvec++; nerr++;
                $display("FAIL a_done_no_write: got done=1, expected 0");
            end
        end
    end

    always @(negedge clk) begin
        if (mon_b) begin
            if (mem_we_b) begin
                if (qb.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL b_unexpected_write: got addr %0h data %0h, expected none", mem_waddr_b, mem_wdata_b);
                end else begin
                    wr_t e;
                    e = qb.pop_front();
                    chk("b_wr", {mem_waddr_b, mem_wdata_b, done_b}, {e.a, e.d, e.dn});
                end
            end else if (done_b) begin
                nvec++; nerr++;
                $display("FAIL b_done_no_write: got done=1, expected 0");
            end
        end
    end

    task automatic wait_idle_a();
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("a_idle_timeout", busy, 0);
    endtask

    task automatic wait_idle_b();
        for (int k = 0; k < 40 && busy_b; k++) tick();
        chk("b_idle_timeout", busy_b, 0);
    endtask

    task automatic send_a(input logic [7:0] d, input logic lst);
        load_valid = 1'b1; load_data = d; load_last = lst;
        chk("a_ready", load_ready, 1);
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        int n;
        n = j.mode ? 3 : int'(j.cnt) + 1;
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.a  = j.base + 12'(i);
            e.d  = j.mode ? (i == 0 ? j.e0 : (i == 1 ? j.e1 : j.e2)) : vregs[i];
            e.dn = (i == n - 1);
            qa.push_back(e);
        end
        st_mode = j.mode; st_base = j.base; st_count = j.cnt; st_value = j.val;
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
        chk("job_lat1_we", {busy, mem_we}, 2'b10);
        tick();
        chk("job_lat2_we", {mem_we, mem_waddr}, {1'b1, j.base});
        wait_idle_a();
        chk("job_q_empty", qa.size(), 0);
    endtask

    job_t jobs [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) vregs[i] = 8'h50 + 8'(i);
        vregs[0] = 8'hA0; vregs[1] = 8'hA1; vregs[2] = 8'hA2; vregs[3] = 8'hA3;
        jobs[0] = '{1'b0, 12'h300, 4'd3, 8'd0,   8'h00, 8'h00, 8'h00};
        jobs[1] = '{1'b0, 12'hFFF, 4'd1, 8'd0,   8'h00, 8'h00, 8'h00};
        jobs[2] = '{1'b1, 12'h400, 4'd0, 8'd254, 8'h02, 8'h05, 8'h04};
        jobs[3] = '{1'b1, 12'h410, 4'd0, 8'd0,   8'h00, 8'h00, 8'h00};
        jobs[4] = '{1'b1, 12'h420, 4'd0, 8'd9,   8'h00, 8'h00, 8'h09};

        // reset state
        #12;
        chk("rst_outputs", {mem_we, mem_waddr, mem_wdata, reg_idx, load_ready, busy, done, overflow}, '0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // reset in the middle of a load
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        chk("midrst_we_before", mem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {mem_we, mem_waddr, mem_wdata, reg_idx, load_ready, busy, done, overflow}, '0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        mon_a = 1'b1; mon_b = 1'b1;
        qa.push_back('{12'h200, 8'h77, 1'b1});
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_a(8'h77, 1'b1);
        wait_idle_a();

        // load with a gap after byte 2
        qa.push_back('{12'h200, 8'h12, 1'b0});
        qa.push_back('{12'h201, 8'h00, 1'b0});
        qa.push_back('{12'h202, 8'h6A, 1'b0});
        qa.push_back('{12'h203, 8'h05, 1'b1});
        load_start = 1'b1; tick(); load_start = 1'b0;
        send_a(8'h12, 1'b0);
        send_a(8'h00, 1'b0);
        tick(); tick();
        send_a(8'h6A, 1'b0);
        send_a(8'h05, 1'b1);
        wait_idle_a();
        chk("load_overflow", overflow, 0);
        chk("load_q_empty", qa.size(), 0);

        // overflow on the instance based at 0xFFE
        qb.push_back('{12'hFFE, 8'hB1, 1'b0});
        qb.push_back('{12'hFFF, 8'hB2, 1'b1});
        load_start_b = 1'b1; tick(); load_start_b = 1'b0;
        load_valid = 1'b1; load_data = 8'hB1; tick();
        load_data = 8'hB2; tick();
        load_data = 8'hB3;
        chk("ovf_rdy_fin", load_ready_b, 0);
        chk("ovf_done", {mem_we_b, done_b}, 2'b11);
        tick();
        chk("ovf_rdy_idle", load_ready_b, 0);
        chk("ovf_sticky", overflow_b, 1);
        tick();
        load_valid = 1'b0;
        chk("ovf_sticky2", overflow_b, 1);
        wait_idle_b();
        load_start_b = 1'b1; tick(); load_start_b = 1'b0;
        chk("ovf_cleared", overflow_b, 0);
        qb.push_back('{12'hFFE, 8'hC1, 1'b1});
        load_valid = 1'b1; load_data = 8'hC1; load_last = 1'b1;
        chk("b_ready", load_ready_b, 1);
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        wait_idle_b();
        chk("b_q_empty", qb.size(), 0);

        // dump and BCD jobs
        foreach (jobs[i]) run_job(jobs[i]);

        // simultaneous load_start and st_req: load wins
        qa.push_back('{12'h200, 8'h99, 1'b1});
        st_mode = 1'b0; st_base = 12'h500; st_count = 4'd2;
        load_start = 1'b1; st_req = 1'b1; tick(); load_start = 1'b0; st_req = 1'b0;
        chk("arb_in_load", load_ready, 1);
        send_a(8'h99, 1'b1);
        wait_idle_a();
        tick(); tick();
        chk("arb_q_empty", qa.size(), 0);

        // request while busy is ignored; request at first idle cycle is accepted
        for (int i = 0; i < 3; i++) qa.push_back('{12'h310 + 12'(i), vregs[i], i == 2});
        st_mode = 1'b0; st_base = 12'h310; st_count = 4'd2;
        st_req = 1'b1; tick(); st_req = 1'b0;
        tick();
        st_mode = 1'b1; st_base = 12'h700; st_value = 8'd77;
        st_req = 1'b1; tick(); st_req = 1'b0;
        wait_idle_a();
        qa.push_back('{12'h600, 8'h01, 1'b0});
        qa.push_back('{12'h601, 8'h02, 1'b0});
        qa.push_back('{12'h602, 8'h03, 1'b1});
        st_mode = 1'b1; st_base = 12'h600; st_value = 8'd123;
        st_req = 1'b1; tick(); st_req = 1'b0;
        chk("back_to_back_busy", busy, 1);
        wait_idle_a();
        tick(); tick();
        chk("final_q_empty", qa.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
